// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the instruction-fetch path: fetch FSM states,
// bus widths and the bubble instruction.
package cpu_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_DATA_W = 32;

    localparam logic [INST_DATA_W-1:0] INST_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10,
        HOLD = 2'b11
    } fetch_state_e;

    // Fetch PCs must be word aligned; any low bit set is an address error.
    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return (pc_lo != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// Output register toward IF/ID: holds one instruction, its PC and address-error
// flag until the consumer takes it; a flush empties it and restores the bubble.
module fetch_out_buf
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_W,
    parameter int                DATA_W   = INST_DATA_W,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(INST_NOP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_inst_i,
    input  logic [ADDR_W-1:0] load_pc_i,
    input  logic              load_adel_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              adel_o
);

    logic              valid_q;
    logic [DATA_W-1:0] inst_q;
    logic [ADDR_W-1:0] pc_q;
    logic              adel_q;

    // Flush wins over load and drain so a killed slot never reaches IF/ID.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            pc_q    <= '0;
            adel_q  <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            adel_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            inst_q  <= load_inst_i;
            pc_q    <= load_pc_i;
            adel_q  <= load_adel_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            adel_q  <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;
    assign adel_o  = adel_q;

endmodule

// File: rtl/inst_fetch_if.sv
// Instruction-fetch bus master: issues one read per PC on the SRAM-like bus,
// strobes pc_en on address acceptance and hands the result to IF/ID.
module inst_fetch_if
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_W,
    parameter int                DATA_W   = INST_DATA_W,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(INST_NOP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    output logic              pc_en,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [DATA_W-1:0] inst_rdata,
    output logic              inst_valid_o,
    input  logic              id_ready_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_adel_o
);

    fetch_state_e      state_q;
    logic              discard_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;

    logic              xfer_s;
    logic              early_req_s;
    logic              buf_load_s;
    logic [DATA_W-1:0] buf_inst_s;
    logic [ADDR_W-1:0] buf_pc_s;
    logic              buf_adel_s;

    // A HOLD hand-off issues the next aligned request in the same cycle so a
    // zero-wait bus sustains one instruction every two cycles.
    assign xfer_s      = inst_valid_o & id_ready_i & ~flush_i;
    assign early_req_s = (state_q == HOLD) & xfer_s & ~pc_misaligned(pc_i[1:0]);
    assign inst_req    = req_q | early_req_s;
    assign inst_addr   = early_req_s ? pc_i : addr_q;
    assign pc_en       = inst_req & inst_addr_ok;

    // Selects what the output buffer captures: a fetched word or an address error.
    always_comb begin
        buf_load_s = 1'b0;
        buf_inst_s = NOP_INST;
        buf_pc_s   = addr_q;
        buf_adel_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (!flush_i && pc_misaligned(pc_i[1:0])) begin
                    buf_load_s = 1'b1;
                    buf_pc_s   = pc_i;
                    buf_adel_s = 1'b1;
                end else begin
                    buf_load_s = 1'b0;
                end
            end
            DATA: begin
                if (inst_data_ok && !discard_q && !flush_i) begin
                    buf_load_s = 1'b1;
                    buf_inst_s = inst_rdata;
                end else begin
                    buf_load_s = 1'b0;
                end
            end
            default: buf_load_s = 1'b0;
        endcase
    end

    // Fetch FSM; the request must stay up through a flush until the bus accepts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!flush_i) begin
                        if (pc_misaligned(pc_i[1:0])) begin
                            state_q <= HOLD;
                        end else begin
                            state_q <= ADDR;
                            req_q   <= 1'b1;
                            addr_q  <= pc_i;
                        end
                    end
                end
                ADDR: begin
                    if (flush_i) begin
                        discard_q <= 1'b1;
                    end
                    if (inst_addr_ok) begin
                        req_q   <= 1'b0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (inst_data_ok) begin
                        discard_q <= 1'b0;
                        state_q   <= (discard_q || flush_i) ? IDLE : HOLD;
                    end else if (flush_i) begin
                        discard_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else if (xfer_s) begin
                        if (pc_misaligned(pc_i[1:0])) begin
                            state_q <= IDLE;
                        end else if (inst_addr_ok) begin
                            state_q <= DATA;
                            addr_q  <= pc_i;
                        end else begin
                            state_q <= ADDR;
                            req_q   <= 1'b1;
                            addr_q  <= pc_i;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    discard_q <= 1'b0;
                    req_q     <= 1'b0;
                end
            endcase
        end
    end

    fetch_out_buf #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NOP_INST (NOP_INST)
    ) u_out_buf (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .load_i      (buf_load_s),
        .load_inst_i (buf_inst_s),
        .load_pc_i   (buf_pc_s),
        .load_adel_i (buf_adel_s),
        .ready_i     (id_ready_i),
        .valid_o     (inst_valid_o),
        .inst_o      (inst_o),
        .pc_o        (inst_pc_o),
        .adel_o      (inst_adel_o)
    );

endmodule

// File: tb/tb_inst_fetch_if.sv
// Scoreboard bench for inst_fetch_if: directed bus transactions push expected
// deliveries; a negedge monitor pops and compares every IF/ID hand-off.
module tb_inst_fetch_if;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        pc_en;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        inst_valid_o;
    logic        id_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_adel_o;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        adel;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp;
    int   n_err;
    int   pcen_cnt;

    inst_fetch_if dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .flush_i      (flush_i),
        .pc_en        (pc_en),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .inst_valid_o (inst_valid_o),
        .id_ready_i   (id_ready_i),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_adel_o  (inst_adel_o)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h, required %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] inst, input logic [31:0] pc, input logic adel);
        exp_t e;
        e.inst = inst;
        e.pc   = pc;
        e.adel = adel;
        sb_q.push_back(e);
    endtask

    // Monitor: compare each hand-off against the scoreboard, watch the bubble value.
    always @(negedge clk) begin
        exp_t e;
        if (rst && inst_valid_o && id_ready_i && !flush_i) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_inst: actual pc %h inst %h, required no delivery",
                         inst_pc_o, inst_o);
            end else begin
                e = sb_q.pop_front();
                chk("inst_o", inst_o, e.inst);
                chk("inst_pc_o", inst_pc_o, e.pc);
                chk("inst_adel_o", {31'd0, inst_adel_o}, {31'd0, e.adel});
            end
        end
        if (!inst_valid_o) begin
            chk("nop_when_invalid", inst_o, 32'h0000_0000);
        end
        if (pc_en) begin
            pcen_cnt++;
        end
    end

    // mode: 0 normal, 1 flush in DATA before data_ok, 2 flush with data_ok, 3 flush in ADDR
    task automatic fetch(input logic [31:0] pc, input logic [31:0] nxt, input int a_dly,
                         input logic [31:0] rd, input int mode, input bit hold);
        int p0;
        bit got;
        p0   = pcen_cnt;
        pc_i = pc;
        got  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (inst_req) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL req_timeout: inst_req low, required high for pc %h", pc);
            return;
        end
        chk("inst_addr", inst_addr, pc);
        for (int k = 0; k < a_dly; k++) begin
            if (mode == 3 && k == 0) begin
                flush_i = 1'b1;
                pc_i    = nxt;
            end
            #1;
            chk("req_hold", {31'd0, inst_req}, 32'd1);
            chk("addr_hold", inst_addr, pc);
            chk("pc_en_early", {31'd0, pc_en}, 32'd0);
            tick();
            flush_i = 1'b0;
        end
        inst_addr_ok = 1'b1;
        #1;
        chk("pc_en_pulse", {31'd0, pc_en}, 32'd1);
        chk("addr_at_ok", inst_addr, pc);
        tick();
        inst_addr_ok = 1'b0;
        if (mode == 0) pc_i = nxt;
        #1;
        chk("req_drop", {31'd0, inst_req}, 32'd0);
        if (mode == 1) begin
            flush_i = 1'b1;
            pc_i    = nxt;
            tick();
            flush_i      = 1'b0;
            inst_data_ok = 1'b1;
            inst_rdata   = rd;
        end else if (mode == 2) begin
            flush_i      = 1'b1;
            pc_i         = nxt;
            inst_data_ok = 1'b1;
            inst_rdata   = rd;
        end else begin
            inst_data_ok = 1'b1;
            inst_rdata   = rd;
            if (mode == 0) push_exp(rd, pc, 1'b0);
        end
        if (hold) id_ready_i = 1'b0;
        tick();
        inst_data_ok = 1'b0;
        flush_i      = 1'b0;
        #1;
        if (mode != 0) chk("dropped_valid", {31'd0, inst_valid_o}, 32'd0);
        else           chk("valid_after_data", {31'd0, inst_valid_o}, 32'd1);
        chk("pc_en_once", 32'(pcen_cnt - p0), 32'd1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req", {31'd0, inst_req}, 32'd0);
        chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_inst", inst_o, 32'h0000_0000);
        chk("rst_pc", inst_pc_o, 32'h0000_0000);
        chk("rst_adel", {31'd0, inst_adel_o}, 32'd0);
        chk("rst_addr", inst_addr, 32'h0000_0000);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        n_cmp        = 0;
        n_err        = 0;
        pcen_cnt     = 0;
        rst          = 1'b0;
        pc_i         = 32'hbfc0_0000;
        flush_i      = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0000_0000;
        id_ready_i   = 1'b1;
        repeat (2) tick();
        #1;
        chk_reset_outputs();
        rst = 1'b1;

        fetch(32'hbfc0_0000, 32'hbfc0_0004, 0, 32'h3c08_0001, 0, 1'b0);
        fetch(32'hbfc0_0004, 32'hbfc0_0008, 3, 32'h2409_0002, 0, 1'b1);

        // Consumer stalls four cycles: output frozen, no new request.
        for (int k = 0; k < 4; k++) begin
            chk("stall_valid", {31'd0, inst_valid_o}, 32'd1);
            chk("stall_inst", inst_o, 32'h2409_0002);
            chk("stall_pc", inst_pc_o, 32'hbfc0_0004);
            chk("stall_no_req", {31'd0, inst_req}, 32'd0);
            tick();
        end
        id_ready_i = 1'b1;
        #1;
        chk("ready_same_cycle_req", {31'd0, inst_req}, 32'd1);
        chk("ready_same_cycle_addr", inst_addr, 32'hbfc0_0008);

        fetch(32'hbfc0_0008, 32'hbfc0_000c, 0, 32'h8d2a_0010, 0, 1'b0);
        fetch(32'hbfc0_000c, 32'h8000_1000, 1, 32'hdead_beef, 1, 1'b0);
        fetch(32'h8000_1000, 32'h8000_1004, 0, 32'h27bd_fff0, 0, 1'b0);
        fetch(32'h8000_1004, 32'h8000_2000, 0, 32'h0bad_c0de, 2, 1'b0);
        fetch(32'h8000_2000, 32'h8000_3000, 2, 32'h1111_1111, 3, 1'b0);
        fetch(32'h8000_3000, 32'h8000_3004, 0, 32'h0085_1021, 0, 1'b1);

        // Flush lands on the hand-off cycle: nothing delivered, no pc_en.
        id_ready_i   = 1'b1;
        flush_i      = 1'b1;
        inst_addr_ok = 1'b1;
        pc_i         = 32'hbfc0_0002;
        void'(sb_q.pop_back());
        #1;
        chk("flush_hold_no_req", {31'd0, inst_req}, 32'd0);
        chk("flush_hold_no_pc_en", {31'd0, pc_en}, 32'd0);
        tick();
        flush_i      = 1'b0;
        inst_addr_ok = 1'b0;
        id_ready_i   = 1'b0;
        #1;
        chk("flush_hold_valid_low", {31'd0, inst_valid_o}, 32'd0);
        chk("idle_no_req", {31'd0, inst_req}, 32'd0);
        push_exp(32'h0000_0000, 32'hbfc0_0002, 1'b1);
        tick();
        chk("adel_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("adel_flag", {31'd0, inst_adel_o}, 32'd1);
        chk("adel_inst", inst_o, 32'h0000_0000);
        chk("adel_pc", inst_pc_o, 32'hbfc0_0002);
        chk("adel_no_req", {31'd0, inst_req}, 32'd0);
        chk("adel_no_pc_en", {31'd0, pc_en}, 32'd0);
        tick();
        chk("adel_stall_no_req", {31'd0, inst_req}, 32'd0);
        id_ready_i = 1'b1;
        pc_i       = 32'hbfc0_0010;

        fetch(32'hbfc0_0010, 32'hbfc0_0014, 0, 32'h3c1d_8001, 0, 1'b0);

        // Reset while a read is outstanding, then a stale data_ok.
        p0 = pcen_cnt;
        #1;
        chk("pre_rst_req", {31'd0, inst_req}, 32'd1);
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        #1;
        rst  = 1'b0;
        pc_i = 32'hbfc0_0000;
        #1;
        chk_reset_outputs();
        tick();
        rst          = 1'b1;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hcafe_f00d;
        #1;
        chk("stale_no_req", {31'd0, inst_req}, 32'd0);
        chk("stale_valid", {31'd0, inst_valid_o}, 32'd0);
        tick();
        inst_data_ok = 1'b0;
        #1;
        chk("stale_ignored_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("post_rst_req", {31'd0, inst_req}, 32'd1);
        chk("rst_fetch_pc_en_once", 32'(pcen_cnt - p0), 32'd1);

        fetch(32'hbfc0_0000, 32'hbfc0_0004, 0, 32'h3c08_0001, 0, 1'b0);
        repeat (3) tick();
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
